// File: rtl/sync_ram_clr.sv
// sync_ram_clr: single-port synchronous RAM with registered inputs, registered read data
// and a clear sequencer that fills every word with INIT_VAL after reset or on request.
module sync_ram_clr #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 5,
  parameter int RDW_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              we,
  input  logic              clr_req,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              clr_done
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, cnt_q, cnt_d, mem_addr;
  logic [DATA_W-1:0] din_q, dout_q, dout_d, mem_wdata;
  logic we_q, mem_we;
  logic [DATA_W-1:0] mem [DEPTH];
  // The sequencer owns the single write port while clearing; an accepted clr_req drops the pending user write.
  always_comb begin
    busy = state_q == CLEAR;
    clr_done = busy && cnt_q == ADDR_W'(DEPTH - 1);
    state_d = busy ? (clr_done ? IDLE : CLEAR) : (clr_req ? CLEAR : IDLE);
    cnt_d = busy ? cnt_q + ADDR_W'(1) : '0;
    mem_we = busy || (we_q && !clr_req);
    mem_addr = busy ? cnt_q : addr_q;
    mem_wdata = busy ? INIT_VAL : din_q;
    dout_d = (busy || clr_req) ? '0 : (we_q && RDW_MODE != 0) ? din_q : mem[addr_q];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      dout_q <= '0;
      addr_q <= '0;
      din_q <= '0;
      we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dout_q <= dout_d;
      addr_q <= addr;
      din_q <= din;
      we_q <= we;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign dout = dout_q;
endmodule

// File: tb/tb_sync_ram_clr.sv
// tb_sync_ram_clr: directed plus random checks of sync_ram_clr against an array reference model.
module tb_sync_ram_clr;
  logic clk = 1'b0;
  logic rst = 1'b1, we = 1'b0, clr_req = 1'b0;
  logic [4:0] addr = '0;
  logic [3:0] din = '0;
  logic [3:0] dout0, dout1;
  logic busy0, busy1, done0, done1;
  logic rst2 = 1'b1, we2 = 1'b0;
  logic [2:0] addr2 = '0;
  logic [7:0] din2 = '0, dout2;
  logic busy2, done2;
  logic [3:0] ref_mem [32];
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  sync_ram_clr #(.RDW_MODE(0)) u0 (.clk(clk), .rst(rst), .addr(addr), .din(din), .we(we),
    .clr_req(clr_req), .dout(dout0), .busy(busy0), .clr_done(done0));
  sync_ram_clr #(.RDW_MODE(1)) u1 (.clk(clk), .rst(rst), .addr(addr), .din(din), .we(we),
    .clr_req(clr_req), .dout(dout1), .busy(busy1), .clr_done(done1));
  sync_ram_clr #(.DATA_W(8), .ADDR_W(3), .INIT_VAL(8'hA5)) u2 (.clk(clk), .rst(rst2),
    .addr(addr2), .din(din2), .we(we2), .clr_req(1'b0), .dout(dout2), .busy(busy2),
    .clr_done(done2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [3:0] d);
    addr = 5'(a);
    din = d;
    we = 1'b1;
    tick;
    we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic rd(input int a, input string tag);
    addr = 5'(a);
    we = 1'b0;
    tick;
    tick;
    chk({tag, "_m0"}, 32'(dout0), 32'(ref_mem[a]));
    chk({tag, "_m1"}, 32'(dout1), 32'(ref_mem[a]));
  endtask

  // Counts busy cycles; optionally pulses rst at cycle rst_at or attempts a write to addr 2 mid-clear.
  task automatic run_clear(input int rst_at, input bit poke);
    int n = 0;
    int pulses = 0;
    int pulse_at = -1;
    while (busy0 === 1'b1 && n < 200) begin
      chk("clr_dout0", 32'(dout0), 0);
      chk("clr_dout1", 32'(dout1), 0);
      chk("clr_busy1", 32'(busy1), 1);
      if (done0 === 1'b1) begin
        pulses++;
        pulse_at = n + 1;
      end
      if (poke && n == 3) begin
        addr = 5'd2;
        din = 4'h5;
        we = 1'b1;
      end
      if (poke && n == 4) we = 1'b0;
      if (n == rst_at) begin
        rst = 1'b1;
        tick;
        rst = 1'b0;
        rst_at = -1;
        n = 0;
        continue;
      end
      n++;
      tick;
    end
    chk("busy_len", 32'(n), 32);
    chk("done_cnt", 32'(pulses), 1);
    chk("done_at", 32'(pulse_at), 32);
    chk("done_low_after", 32'(done0), 0);
    for (int i = 0; i < 32; i++) ref_mem[i] = 4'h0;
  endtask

  initial begin
    tick;
    tick;
    chk("rst_dout", 32'(dout0), 0);
    chk("rst_busy", 32'(busy0), 1);
    chk("rst_done", 32'(done0), 0);
    rst = 1'b0;
    run_clear(-1, 1'b0);
    for (int a = 0; a < 32; a++) rd(a, "post_rst");
    wr(10, 4'h7);
    rd(10, "wr_0a");
    rd(11, "rd_0b");
    wr(3, 4'h2);
    addr = 5'd3;
    din = 4'h9;
    we = 1'b1;
    tick;
    we = 1'b0;
    tick;
    chk("rdw_old_m0", 32'(dout0), 32'(ref_mem[3]));
    chk("rdw_new_m1", 32'(dout1), 32'h9);
    ref_mem[3] = 4'h9;
    tick;
    chk("rdw_after_m0", 32'(dout0), 32'h9);
    chk("rdw_after_m1", 32'(dout1), 32'h9);
    for (int i = 0; i < 60; i++) begin
      int a = int'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) wr(a, 4'($urandom));
      else rd(a, "rand");
    end
    for (int a = 0; a < 32; a++) wr(a, 4'(a) ^ 4'hF);
    tick;
    rd(17, "fill");
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    run_clear(-1, 1'b1);
    for (int a = 0; a < 32; a++) rd(a, "post_clr");
    wr(20, 4'hC);
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    run_clear(10, 1'b0);
    for (int a = 18; a < 23; a++) rd(a, "post_rst_mid");
    tick;
    tick;
    rst2 = 1'b0;
    begin
      int n = 0;
      while (busy2 === 1'b1 && n < 100) begin
        n++;
        tick;
      end
      chk("p_busy_len", 32'(n), 8);
    end
    for (int a = 0; a < 8; a++) begin
      addr2 = 3'(a);
      tick;
      tick;
      chk("p_init", 32'(dout2), 32'hA5);
    end
    addr2 = 3'd7;
    din2 = 8'h3C;
    we2 = 1'b1;
    tick;
    we2 = 1'b0;
    tick;
    tick;
    chk("p_wr7", 32'(dout2), 32'h3C);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sync_ram_clr.md
Name: sync_ram_clr

Overview:
- Parametrised single-port synchronous RAM. Successor to the fixed 32x4 registered-input RAM.
- Adds a fully synchronous write (no combinational write path) and a registered read output.
- Adds a selectable read-during-write mode and a hardware clear sequencer that fills every location with INIT_VAL after reset or on request.
- Sits between switch/key input logic and the hex display decoders; also reusable as a general scratch store.

Parameters:
- DATA_W, 4, data word width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W words.
- RDW_MODE, 0, read-during-write to the same address: 0 = dout shows old data, 1 = dout shows new data (write-through).
- INIT_VAL, 0, DATA_W-bit value written to every word by the clear sequencer.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  ADDR_W  word address.
- din  in  DATA_W  write data.
- we  in  1  write enable.
- clr_req  in  1  request a full-memory clear; sampled only in IDLE.
- dout  out  DATA_W  registered read data.
- busy  out  1  high while the clear sequencer owns the memory.
- clr_done  out  1  single-cycle pulse on the final clear write.

Behaviour:
- Input stage: addr, din, we are registered into addr_q, din_q, we_q at every rising edge; rst clears them to 0.
- Array access (state IDLE, edge N+1, using values registered at edge N):
  - if we_q: mem[addr_q] <= din_q.
  - dout <= mem[addr_q], except when we_q=1: RDW_MODE=1 gives dout <= din_q; RDW_MODE=0 gives the pre-write contents.
- Latency: inputs applied before edge N appear on dout after edge N+1 (2 edges). A write is visible to a read issued one cycle later.
- FSM states: CLEAR, IDLE.
  - rst=1: state=CLEAR, cnt=0, busy=1, dout=0, clr_done=0. Memory contents are not touched while rst is held.
  - CLEAR: each edge, mem[cnt] <= INIT_VAL and cnt <= cnt+1. dout held at 0.
  - CLEAR, cnt = DEPTH-1: write the last word, clr_done=1 for that cycle, next state IDLE, busy=0 from the following cycle.
  - IDLE: if clr_req=1 at an edge, next state is CLEAR with cnt=0 and busy=1 from the next cycle. A user write registered in that same cycle is discarded.
- Clear duration: exactly DEPTH cycles after rst deasserts, or after clr_req is accepted.
- During CLEAR:
  - we_q is ignored; user writes are dropped, not queued.
  - clr_req is ignored.
  - the input registers keep sampling normally.
- rst asserted mid-clear: cnt restarts at 0 and a full DEPTH-cycle clear runs after release.
- Address wrap: cnt is ADDR_W+1 bits or compared against DEPTH-1; it never wraps into a second pass.
- No reads or writes outside 0..DEPTH-1: addr width covers exactly the array.
- clr_done is 0 at every cycle except the last clear write.

Test Plan:
- Reset, then release: busy=1 for exactly 32 cycles, clr_done pulses once on cycle 32, dout=0 throughout. Afterwards, reading addresses 0..31 returns 0 each, with 2-cycle latency.
- Write addr=5'h0A din=4'h7 we=1 for one cycle, then we=0 addr=5'h0A: dout=4'h7 two edges after the read address is applied. Reading addr=5'h0B returns 0.
- RDW: mem[3]=4'h2, then write addr=3 din=4'h9. With RDW_MODE=0 the dout for that cycle is 4'h2; with RDW_MODE=1 it is 4'h9. The following read returns 4'h9 in both modes.
- Fill all 32 words with addr^4'hF, then pulse clr_req: busy=1 for 32 cycles, and a write attempted during the clear (addr=2, din=4'h5) is dropped. Afterwards every address reads 0, including addr 2.
- Assert rst for 1 cycle at clear cycle 10: the clear restarts, busy stays high 32 more cycles after release, and clr_done pulses once only.
- Parameter sweep DATA_W=8, ADDR_W=3, INIT_VAL=8'hA5: after reset, busy lasts 8 cycles, all 8 words read 8'hA5, and a write of 8'h3C to addr 7 reads back 8'h3C.
